// File: rtl/mem_1wnr_if.sv
// Request/response bundle for the one-write / N-read memory.
interface mem_1wnr_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int READ_PORTS = 2
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                             init_done_o;
  logic                             write_en_i;
  logic [ADDR_WIDTH-1:0]            addr_write_i;
  logic [DATA_WIDTH-1:0]            data_write_i;
  logic [NB-1:0]                    byte_en_i;
  logic [READ_PORTS-1:0]            read_en_i;
  logic [READ_PORTS*ADDR_WIDTH-1:0] addr_read_i;
  logic [READ_PORTS*DATA_WIDTH-1:0] data_read_o;
  logic [READ_PORTS-1:0]            read_valid_o;

  modport master (
    input  init_done_o, data_read_o, read_valid_o,
    output write_en_i, addr_write_i, data_write_i, byte_en_i, read_en_i, addr_read_i
  );

  modport slave (
    output init_done_o, data_read_o, read_valid_o,
    input  write_en_i, addr_write_i, data_write_i, byte_en_i, read_en_i, addr_read_i
  );
endinterface

// File: rtl/mem_1wnr.sv
// One-write / N-read memory with byte enables, optional output register,
// write-to-read bypass and a self-initialising sweep after reset.
module mem_1wnr #(
  parameter int                   ADDR_WIDTH = 4,
  parameter int                   DATA_WIDTH = 8,
  parameter int                   BYTE_WIDTH = 8,
  parameter int                   READ_PORTS = 2,
  parameter int                   OUT_REG    = 0,
  parameter int                   BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic       clk,
  input  logic       rst,
  mem_1wnr_if.slave  bus
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic {INIT, READY} state_t;

  state_t                               state, state_next;
  logic [ADDR_WIDTH:0]                  cnt, cnt_next;
  logic [DATA_WIDTH-1:0]                mem [DEPTH];
  logic                                 mem_we;
  logic [ADDR_WIDTH-1:0]                mem_addr;
  logic [DATA_WIDTH-1:0]                mem_wdata;
  logic [DATA_WIDTH-1:0]                merged;
  logic                                 wr_hit;
  logic [READ_PORTS-1:0]                rd_accept;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_word;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] s1_data;
  logic [READ_PORTS-1:0]                s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Word as it will look after the write: new lanes where enabled, old elsewhere.
  always_comb begin
    merged = mem[bus.addr_write_i];
    for (int unsigned k = 0; k < NB; k++)
      if (bus.byte_en_i[k])
        merged[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_write_i[k*BYTE_WIDTH +: BYTE_WIDTH];
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_we     = 1'b0;
    mem_addr   = bus.addr_write_i;
    mem_wdata  = merged;
    wr_hit     = 1'b0;
    rd_accept  = '0;
    unique case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = cnt[ADDR_WIDTH-1:0];
        mem_wdata = INIT_VALUE;
        cnt_next  = cnt + ONE;
        if (cnt == LAST) state_next = READY;
      end
      READY: begin
        wr_hit    = bus.write_en_i;
        mem_we    = bus.write_en_i;
        rd_accept = bus.read_en_i;
      end
      default: ;
    endcase
  end

  assign bus.init_done_o = (state == READY);

  // The array itself is never reset; the sweep rewrites it once rst drops.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      if (BYPASS != 0 && wr_hit &&
          bus.addr_read_i[p*ADDR_WIDTH +: ADDR_WIDTH] == bus.addr_write_i)
        rd_word[p] = merged;
      else
        rd_word[p] = mem[bus.addr_read_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= '0;
      s1_data  <= '0;
    end else begin
      for (int unsigned p = 0; p < READ_PORTS; p++) begin
        s1_valid[p] <= rd_accept[p];
        if (rd_accept[p]) s1_data[p] <= rd_word[p];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [READ_PORTS-1:0][DATA_WIDTH-1:0] s2_data;
      logic [READ_PORTS-1:0]                s2_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= '0;
          s2_data  <= '0;
        end else begin
          for (int unsigned p = 0; p < READ_PORTS; p++) begin
            s2_valid[p] <= s1_valid[p];
            if (s1_valid[p]) s2_data[p] <= s1_data[p];
          end
        end
      end

      assign bus.data_read_o  = s2_data;
      assign bus.read_valid_o = s2_valid;
    end else begin : g_no_reg
      assign bus.data_read_o  = s1_data;
      assign bus.read_valid_o = s1_valid;
    end
  endgenerate
endmodule

// File: tb/tb_mem_1wnr.sv
// Bench for mem_1wnr: two configurations (8-bit/2 ports/latency 1/no bypass and
// 32-bit/3 ports/latency 2/bypass) against an array-and-delay reference model.
module tb_mem_1wnr;
  localparam logic [7:0]  INIT0 = 8'hA5;
  localparam logic [31:0] INIT1 = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_1wnr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8),  .BYTE_WIDTH(8), .READ_PORTS(2)) b0 ();
  mem_1wnr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_PORTS(3)) b1 ();

  mem_1wnr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BYTE_WIDTH(8), .READ_PORTS(2),
             .OUT_REG(0), .BYPASS(0), .INIT_VALUE(INIT0))
    d0 (.clk(clk), .rst(rst), .bus(b0));
  mem_1wnr #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_PORTS(3),
             .OUT_REG(1), .BYPASS(1), .INIT_VALUE(INIT1))
    d1 (.clk(clk), .rst(rst), .bus(b1));

  // Stimulus, held at the widest configuration and narrowed per DUT.
  logic        we [2];
  logic [3:0]  wa [2];
  logic [31:0] wd [2];
  logic [3:0]  be [2];
  logic [2:0]  re [2];
  logic [3:0]  ra [2][3];

  assign b0.write_en_i   = we[0];
  assign b0.addr_write_i = wa[0];
  assign b0.data_write_i = wd[0][7:0];
  assign b0.byte_en_i    = be[0][0:0];
  assign b0.read_en_i    = re[0][1:0];
  assign b0.addr_read_i  = {ra[0][1], ra[0][0]};
  assign b1.write_en_i   = we[1];
  assign b1.addr_write_i = wa[1];
  assign b1.data_write_i = wd[1];
  assign b1.byte_en_i    = be[1];
  assign b1.read_en_i    = re[1];
  assign b1.addr_read_i  = {ra[1][2], ra[1][1], ra[1][0]};

  // Reference model configuration and state.
  int          rp  [2] = '{2, 3};
  int          lat [2] = '{1, 2};
  int          byp [2] = '{0, 1};
  int          nb  [2] = '{1, 4};
  logic [31:0] msk [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
  logic [31:0] ini [2] = '{32'h0000_00A5, 32'hA5A5_A5A5};
  logic [31:0] m   [2][16];
  logic [31:0] ed  [2][3];
  logic [31:0] pd  [2][3];
  logic        ev  [2][3];
  logic        pv  [2][3];
  int          edges;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       be;
    logic       re;
    logic [3:0] ra;
    logic       ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(int d, logic [31:0] old, logic [31:0] nw, logic [3:0] e);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < nb[d]; k++)
      if (e[k]) r[k*8 +: 8] = nw[k*8 +: 8];
    return r & msk[d];
  endfunction

  task automatic model_reset();
    edges = 0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 3; p++) begin
        ev[d][p] = 1'b0; ed[d][p] = '0; pv[d][p] = 1'b0; pd[d][p] = '0;
      end
  endtask

  // Effect of one rising edge with the currently driven inputs.
  task automatic model_edge();
    logic [31:0] w;
    logic        acc;
    logic        ready;
    if (rst) return;
    ready = (edges >= 16);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < rp[d]; p++) begin
        if (byp[d] != 0 && we[d] && wa[d] == ra[d][p])
          w = merge(d, m[d][ra[d][p]], wd[d], be[d]);
        else
          w = m[d][ra[d][p]];
        acc = ready && re[d][p];
        if (lat[d] == 1) begin
          ev[d][p] = acc;
          if (acc) ed[d][p] = w;
        end else begin
          ev[d][p] = pv[d][p];
          if (pv[d][p]) ed[d][p] = pd[d][p];
          pv[d][p] = acc;
          if (acc) pd[d][p] = w;
        end
      end
      if (ready && we[d]) m[d][wa[d]] = merge(d, m[d][wa[d]], wd[d], be[d]);
    end
    if (!ready) begin
      for (int d = 0; d < 2; d++) m[d][edges] = ini[d];
      edges++;
    end
  endtask

  task automatic compare_all();
    chk("done0", 0, 32'(b0.init_done_o), 32'(edges >= 16));
    chk("done1", 0, 32'(b1.init_done_o), 32'(edges >= 16));
    for (int p = 0; p < 2; p++) begin
      chk("valid0", p, 32'(b0.read_valid_o[p]), 32'(ev[0][p]));
      chk("data0",  p, 32'(b0.data_read_o[p*8 +: 8]), ed[0][p]);
    end
    for (int p = 0; p < 3; p++) begin
      chk("valid1", p, 32'(b1.read_valid_o[p]), 32'(ev[1][p]));
      chk("data1",  p, b1.data_read_o[p*32 +: 32], ed[1][p]);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      we[d] = 1'b0; wa[d] = '0; wd[d] = '0; be[d] = '0; re[d] = '0;
      for (int p = 0; p < 3; p++) ra[d][p] = '0;
    end
  endtask

  task automatic rand_inputs();
    for (int d = 0; d < 2; d++) begin
      we[d] = 1'($urandom);
      wa[d] = 4'($urandom);
      wd[d] = $urandom;
      be[d] = 4'($urandom);
      re[d] = 3'($urandom);
      for (int p = 0; p < 3; p++)
        ra[d][p] = ($urandom_range(0, 2) == 0) ? wa[d] : 4'($urandom);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] vexp [5];
    vexp = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b000};

    tbl[0] = '{1'b1, 4'd7, 8'h3C, 1'b1, 1'b1, 4'd7,  1'b1, 8'hA5};
    tbl[1] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd7,  1'b1, 8'h3C};
    tbl[2] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd3,  1'b0, 8'h3C};
    tbl[3] = '{1'b1, 4'd2, 8'h5A, 1'b1, 1'b1, 4'd2,  1'b1, 8'hA5};
    tbl[4] = '{1'b1, 4'd2, 8'h00, 1'b1, 1'b1, 4'd2,  1'b1, 8'h5A};
    tbl[5] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd2,  1'b1, 8'h00};
    tbl[6] = '{1'b1, 4'd7, 8'hFF, 1'b0, 1'b1, 4'd7,  1'b1, 8'h3C};
    tbl[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd7,  1'b1, 8'h3C};
    tbl[8] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd15, 1'b1, 8'hA5};
    tbl[9] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd0,  1'b1, 8'hA5};

    clear_inputs();
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Requests during a partial sweep, then reset mid-sweep.
    for (int i = 0; i < 8; i++) begin
      rand_inputs(); we[0] = 1'b1; we[1] = 1'b1; re[0] = '1; re[1] = '1;
      cycle();
    end
    pulse_reset();

    // Full sweep with requests asserted throughout; done rises on edge 16.
    for (int i = 0; i < 16; i++) begin
      rand_inputs(); we[0] = 1'b1; we[1] = 1'b1; re[0] = '1; re[1] = '1;
      cycle();
      chk("init_edge", i, 32'(b0.init_done_o), 32'(i == 15));
    end
    clear_inputs();

    // Every entry still holds INIT_VALUE.
    for (int a = 0; a < 16; a++) begin
      re[0] = 3'b001; ra[0][0] = 4'(a);
      re[1] = 3'b001; ra[1][0] = 4'(a);
      cycle();
      chk("init_rd", a, 32'(b0.data_read_o[7:0]), 32'(INIT0));
    end
    clear_inputs();
    cycle();

    // Directed vectors on the latency-1, no-bypass instance.
    foreach (tbl[i]) begin
      we[0] = tbl[i].we; wa[0] = tbl[i].wa; wd[0] = 32'(tbl[i].wd); be[0] = 4'(tbl[i].be);
      re[0] = {1'b0, tbl[i].re, tbl[i].re}; ra[0][0] = tbl[i].ra; ra[0][1] = tbl[i].ra;
      cycle();
      chk("tbl_v", i, 32'(b0.read_valid_o[0]), 32'(tbl[i].ev));
      chk("tbl_d", i, 32'(b0.data_read_o[7:0]), 32'(tbl[i].ed));
    end
    clear_inputs();

    // Byte-enable merge.
    we[1] = 1'b1; wa[1] = 4'd3; wd[1] = 32'h1122_3344; be[1] = 4'b1111;
    cycle();
    wd[1] = 32'hAABB_CCDD; be[1] = 4'b0101;
    cycle();
    clear_inputs(); re[1] = 3'b001; ra[1][0] = 4'd3;
    cycle();
    clear_inputs();
    cycle();
    chk("byte_en", 0, b1.data_read_o[31:0], 32'h11BB_33DD);

    // Same-cycle collision with bypass on two ports.
    we[1] = 1'b1; wa[1] = 4'd7; wd[1] = 32'h0000_003C; be[1] = 4'b0001;
    re[1] = 3'b011; ra[1][0] = 4'd7; ra[1][1] = 4'd7;
    cycle();
    clear_inputs();
    cycle();
    chk("bypass", 0, b1.data_read_o[31:0], 32'hA5A5_A53C);

    // Three ports, shared address, back-to-back requests, then hold.
    re[1] = 3'b111; ra[1][0] = 4'd1; ra[1][1] = 4'd1; ra[1][2] = 4'd9;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("b2b_valid", i, 32'(b1.read_valid_o), 32'(vexp[i]));
      if (i < 2) begin
        ra[1][0] = 4'(2 + 3*i); ra[1][1] = 4'(3 + 3*i); ra[1][2] = 4'(4 + 3*i);
      end else begin
        re[1] = '0;
      end
    end

    // Reset with a request sitting in the output stage.
    re[1] = 3'b101; ra[1][0] = 4'd3; ra[1][2] = 4'd7;
    cycle();
    clear_inputs();
    pulse_reset();
    for (int i = 0; i < 16; i++) cycle();

    // Randomised traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
